// File: rtl/ext_razor_collector.sv
// Razor-aware extrinsic collector: drops razor-flagged samples, requests replays and queues
// clean words toward the interleaver. Define ERR_COUNT_EN to build the razor error counter.

module ext_razor_collector #(
  parameter int M          = 6,
  parameter int DEPTH      = 8,
  parameter int MAX_REPLAY = 3
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic [M-1:0] be1_DFF,
  input  logic         be1_valid,
  input  logic         Error_current_Section,
  output logic         replay_req,
  output logic         stall_out,
  output logic [M:0]   out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         fault_sticky,
  output logic         overflow_sticky,
  output logic [15:0]  err_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int RW = (MAX_REPLAY > 0) ? $clog2(MAX_REPLAY + 1) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [RW-1:0] MAX_CNT  = RW'(MAX_REPLAY);

  typedef enum logic {ST_RUN, ST_REPLAY} state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] replay_cnt_q, replay_cnt_d;
  logic [M:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full, pop, take, err_take, at_limit, forced, replay_set, push;
  logic [M:0]    push_data, head_d;

  // A full FIFO only stalls when the head is not leaving this cycle, so a
  // simultaneous pop frees the slot for the incoming sample.
  always_comb begin
    full       = (count_q == FULL_CNT);
    pop        = out_valid & out_ready;
    stall_out  = replay_req | (full & ~out_ready);
    take       = be1_valid & ~stall_out;
    err_take   = take & Error_current_Section;
    at_limit   = (replay_cnt_q == MAX_CNT);
    forced     = err_take & at_limit;
    replay_set = err_take & ~at_limit;
    push       = take & ~replay_set;
    push_data  = {forced, be1_DFF};
  end

  always_comb begin
    state_d      = state_q;
    replay_cnt_d = replay_cnt_q;
    case (state_q)
      ST_RUN, ST_REPLAY: begin
        if (replay_set) begin
          state_d      = ST_REPLAY;
          replay_cnt_d = replay_cnt_q + RW'(1);
        end else if (push) begin
          state_d      = ST_RUN;
          replay_cnt_d = '0;
        end
      end
      default: begin
        state_d      = ST_RUN;
        replay_cnt_d = '0;
      end
    endcase
  end

  // The output register holds the head; a push that becomes the new head bypasses memory.
  always_comb begin
    count_d  = count_q + CW'(push) - CW'(pop);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    if (push && ((count_q == '0) || ((count_q == CW'(1)) && pop)))
      head_d = push_data;
    else
      head_d = mem[rd_ptr_d];
  end

  always_ff @(posedge Clock) begin
    if (!Reset && push)
      mem[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q         <= ST_RUN;
      replay_cnt_q    <= '0;
      replay_req      <= 1'b0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      out_valid       <= 1'b0;
      out_data        <= '0;
      fault_sticky    <= 1'b0;
      overflow_sticky <= 1'b0;
    end else begin
      state_q         <= state_d;
      replay_cnt_q    <= replay_cnt_d;
      replay_req      <= replay_set;
      wr_ptr_q        <= wr_ptr_q + AW'(push);
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      out_valid       <= (count_d != '0);
      out_data        <= head_d;
      fault_sticky    <= fault_sticky | forced;
      overflow_sticky <= overflow_sticky | (be1_valid & stall_out);
    end
  end

`ifdef ERR_COUNT_EN
  logic [15:0] err_count_q;

  always_ff @(posedge Clock) begin
    if (Reset)
      err_count_q <= '0;
    else if (err_take && (err_count_q != 16'hFFFF))
      err_count_q <= err_count_q + 16'd1;
  end

  assign err_count = err_count_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_ext_razor_collector.sv
// Self-checking bench for ext_razor_collector: directed scenarios plus randomized traffic
// checked against a queue-based reference model.

module tb_ext_razor_collector;

  localparam int M          = 6;
  localparam int DEPTH      = 8;
  localparam int MAX_REPLAY = 3;

  logic         clk = 1'b0;
  logic         Reset;
  logic [M-1:0] be1_DFF;
  logic         be1_valid;
  logic         Error_current_Section;
  logic         replay_req;
  logic         stall_out;
  logic [M:0]   out_data;
  logic         out_valid;
  logic         out_ready;
  logic         fault_sticky;
  logic         overflow_sticky;
  logic [15:0]  err_count;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [M:0] mq[$];
  logic       m_pending;
  logic       m_fault;
  logic       m_ovf;
  logic       m_stall_exp;
  int         m_retries;
  int         m_errs;
  logic       obs_stall;

  always #5 clk = ~clk;

  ext_razor_collector #(.M(M), .DEPTH(DEPTH), .MAX_REPLAY(MAX_REPLAY)) dut (
    .Clock                (clk),
    .Reset                (Reset),
    .be1_DFF              (be1_DFF),
    .be1_valid            (be1_valid),
    .Error_current_Section(Error_current_Section),
    .replay_req           (replay_req),
    .stall_out            (stall_out),
    .out_data             (out_data),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .fault_sticky         (fault_sticky),
    .overflow_sticky      (overflow_sticky),
    .err_count            (err_count)
  );

  function automatic logic [15:0] exp_err_count();
`ifdef ERR_COUNT_EN
    return 16'(m_errs);
`else
    return 16'd0;
`endif
  endfunction

  task automatic model_clear();
    mq.delete();
    m_pending = 1'b0;
    m_fault   = 1'b0;
    m_ovf     = 1'b0;
    m_retries = 0;
    m_errs    = 0;
  endtask

  task automatic do_reset();
    Reset                 = 1'b1;
    be1_valid             = 1'b0;
    be1_DFF               = '0;
    Error_current_Section = 1'b0;
    out_ready             = 1'b0;
    @(posedge clk);
    #1;
    Reset = 1'b0;
    model_clear();
  endtask

  // One clock of stimulus; the model advances on the same edge as the DUT.
  task automatic step(input logic v, input logic [M-1:0] d, input logic e, input logic r);
    logic       do_pop;
    logic       do_push;
    logic       pend_n;
    logic [M:0] pd;
    be1_valid             = v;
    be1_DFF               = d;
    Error_current_Section = e;
    out_ready             = r;
    m_stall_exp = m_pending || ((mq.size() == DEPTH) && !r);
    #1;
    obs_stall = stall_out;
    @(posedge clk);
    do_pop  = (mq.size() != 0) && r;
    do_push = 1'b0;
    pend_n  = 1'b0;
    pd      = '0;
    if (v && m_stall_exp) begin
      m_ovf = 1'b1;
    end else if (v && e) begin
      if (m_errs < 65535) m_errs++;
      if (m_retries == MAX_REPLAY) begin
        do_push   = 1'b1;
        pd        = {1'b1, d};
        m_fault   = 1'b1;
        m_retries = 0;
      end else begin
        m_retries++;
        pend_n = 1'b1;
      end
    end else if (v) begin
      do_push   = 1'b1;
      pd        = {1'b0, d};
      m_retries = 0;
    end
    if (do_pop) void'(mq.pop_front());
    if (do_push) mq.push_back(pd);
    m_pending = pend_n;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("[TB] FAIL reset_out_data: got %h want 0", out_data); end
    checks++; if (replay_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_replay_req: got %b want 0", replay_req); end
    checks++; if (stall_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall_out: got %b want 0", stall_out); end
    checks++; if (fault_sticky !== 1'b0) begin errors++; $display("[TB] FAIL reset_fault: got %b want 0", fault_sticky); end
    checks++; if (overflow_sticky !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow: got %b want 0", overflow_sticky); end
    checks++; if (err_count !== 16'd0) begin errors++; $display("[TB] FAIL reset_err_count: got %0d want 0", err_count); end
  endtask

  task automatic test_clean_stream();
    logic [M-1:0] vals [5];
    int pulses;
    vals = '{M'(1), M'(-2), M'(3), M'(-4), M'(5)};
    pulses = 0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, vals[i], 1'b0, 1'b1);
      if (replay_req === 1'b1) pulses++;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL clean_valid[%0d]: got %b want 1", i, out_valid); end
      checks++; if (out_data !== {1'b0, vals[i]}) begin errors++; $display("[TB] FAIL clean_data[%0d]: got %h want %h", i, out_data, {1'b0, vals[i]}); end
    end
    step(1'b0, '0, 1'b0, 1'b1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL clean_drained: got %b want 0", out_valid); end
    checks++; if (pulses != 0) begin errors++; $display("[TB] FAIL clean_no_replay: got %0d pulses want 0", pulses); end
  endtask

  task automatic test_single_error();
    logic [15:0] exp_ec;
`ifdef ERR_COUNT_EN
    exp_ec = 16'd1;
`else
    exp_ec = 16'd0;
`endif
    do_reset();
    step(1'b1, M'(7), 1'b1, 1'b1);
    checks++; if (replay_req !== 1'b1) begin errors++; $display("[TB] FAIL single_replay_pulse: got %b want 1", replay_req); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_no_push: got %b want 0", out_valid); end
    step(1'b0, '0, 1'b0, 1'b1);
    checks++; if (obs_stall !== 1'b1) begin errors++; $display("[TB] FAIL single_stall_in_replay: got %b want 1", obs_stall); end
    checks++; if (replay_req !== 1'b0) begin errors++; $display("[TB] FAIL single_pulse_width: got %b want 0", replay_req); end
    step(1'b1, M'(7), 1'b0, 1'b1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_valid: got %b want 1", out_valid); end
    checks++; if (out_data !== {1'b0, M'(7)}) begin errors++; $display("[TB] FAIL single_data: got %h want %h", out_data, {1'b0, M'(7)}); end
    step(1'b0, '0, 1'b0, 1'b1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_exactly_one: got %b want 0", out_valid); end
    checks++; if (err_count !== exp_ec) begin errors++; $display("[TB] FAIL single_err_count: got %0d want %0d", err_count, exp_ec); end
  endtask

  task automatic test_persistent_error();
    int pulses;
    logic [15:0] exp_ec;
`ifdef ERR_COUNT_EN
    exp_ec = 16'd4;
`else
    exp_ec = 16'd0;
`endif
    pulses = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, M'(-9), 1'b1, 1'b1);
      if (replay_req === 1'b1) pulses++;
      if (i < 3) step(1'b0, '0, 1'b0, 1'b1);
    end
    checks++; if (pulses != 3) begin errors++; $display("[TB] FAIL persist_pulses: got %0d want 3", pulses); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL persist_valid: got %b want 1", out_valid); end
    checks++; if (out_data !== {1'b1, M'(-9)}) begin errors++; $display("[TB] FAIL persist_tagged: got %h want %h", out_data, {1'b1, M'(-9)}); end
    checks++; if (fault_sticky !== 1'b1) begin errors++; $display("[TB] FAIL persist_fault: got %b want 1", fault_sticky); end
    checks++; if (err_count !== exp_ec) begin errors++; $display("[TB] FAIL persist_err_count: got %0d want %0d", err_count, exp_ec); end
    step(1'b1, M'(5), 1'b0, 1'b1);
    checks++; if (obs_stall !== 1'b0) begin errors++; $display("[TB] FAIL persist_run_stall: got %b want 0", obs_stall); end
    checks++; if (out_data !== {1'b0, M'(5)}) begin errors++; $display("[TB] FAIL persist_run_accept: got %h want %h", out_data, {1'b0, M'(5)}); end
    checks++; if (replay_req !== 1'b0) begin errors++; $display("[TB] FAIL persist_run_no_replay: got %b want 0", replay_req); end
  endtask

  task automatic test_full_fifo();
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b1, M'(10 + i), 1'b0, 1'b0);
    checks++; if (stall_out !== 1'b1) begin errors++; $display("[TB] FAIL full_stall: got %b want 1", stall_out); end
    step(1'b1, M'(30), 1'b0, 1'b0);
    checks++; if (overflow_sticky !== 1'b1) begin errors++; $display("[TB] FAIL full_overflow: got %b want 1", overflow_sticky); end
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== {1'b0, M'(10 + i)}) begin
        errors++; $display("[TB] FAIL full_drain[%0d]: got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, {1'b0, M'(10 + i)});
      end
      step(1'b0, '0, 1'b0, 1'b1);
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL full_dropped_absent: got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back_full();
    logic [M:0] exp [DEPTH];
    for (int i = 0; i < DEPTH - 1; i++) exp[i] = {1'b0, M'(21 + i)};
    exp[DEPTH-1] = {1'b0, M'(55)};
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b1, M'(20 + i), 1'b0, 1'b0);
    step(1'b1, M'(55), 1'b0, 1'b1);
    checks++; if (obs_stall !== 1'b0) begin errors++; $display("[TB] FAIL pushpop_stall: got %b want 0", obs_stall); end
    checks++; if (overflow_sticky !== 1'b0) begin errors++; $display("[TB] FAIL pushpop_overflow: got %b want 0", overflow_sticky); end
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== exp[i]) begin
        errors++; $display("[TB] FAIL pushpop_drain[%0d]: got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, exp[i]);
      end
      step(1'b0, '0, 1'b0, 1'b1);
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL pushpop_occupancy: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_during_replay();
    int pulses;
    pulses = 0;
    do_reset();
    step(1'b1, M'(12), 1'b0, 1'b0);
    step(1'b1, M'(7), 1'b1, 1'b0);
    checks++; if (replay_req !== 1'b1) begin errors++; $display("[TB] FAIL rr_pulse_before: got %b want 1", replay_req); end
    do_reset();
    checks++; if (replay_req !== 1'b0) begin errors++; $display("[TB] FAIL rr_replay_req: got %b want 0", replay_req); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rr_flushed: got %b want 0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("[TB] FAIL rr_out_data: got %h want 0", out_data); end
    checks++; if (stall_out !== 1'b0) begin errors++; $display("[TB] FAIL rr_stall: got %b want 0", stall_out); end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, 1'b0, 1'b1);
      if (replay_req === 1'b1) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("[TB] FAIL rr_no_more_replay: got %0d pulses want 0", pulses); end
    step(1'b1, M'(3), 1'b0, 1'b1);
    checks++; if (out_data !== {1'b0, M'(3)} || out_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL rr_run_after: got v=%b d=%h want v=1 d=%h", out_valid, out_data, {1'b0, M'(3)});
    end
  endtask

  task automatic test_random();
    logic         v, e, r;
    logic [M-1:0] d;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      v = (($urandom % 4) != 0);
      e = (($urandom % 3) == 0);
      r = (($urandom % 3) != 0);
      d = M'($urandom);
      step(v, d, e, r);
      checks++; if (obs_stall !== m_stall_exp) begin errors++; $display("[TB] FAIL rand_stall@%0d: got %b want %b", c, obs_stall, m_stall_exp); end
      checks++; if (out_valid !== (mq.size() != 0)) begin errors++; $display("[TB] FAIL rand_valid@%0d: got %b want %b", c, out_valid, mq.size() != 0); end
      if (mq.size() != 0) begin
        checks++; if (out_data !== mq[0]) begin errors++; $display("[TB] FAIL rand_data@%0d: got %h want %h", c, out_data, mq[0]); end
      end
      checks++; if (replay_req !== m_pending) begin errors++; $display("[TB] FAIL rand_replay@%0d: got %b want %b", c, replay_req, m_pending); end
      checks++; if (fault_sticky !== m_fault) begin errors++; $display("[TB] FAIL rand_fault@%0d: got %b want %b", c, fault_sticky, m_fault); end
      checks++; if (overflow_sticky !== m_ovf) begin errors++; $display("[TB] FAIL rand_overflow@%0d: got %b want %b", c, overflow_sticky, m_ovf); end
      checks++; if (err_count !== exp_err_count()) begin errors++; $display("[TB] FAIL rand_err_count@%0d: got %0d want %0d", c, err_count, exp_err_count()); end
    end
  endtask

  initial begin
    Reset                 = 1'b1;
    be1_valid             = 1'b0;
    be1_DFF               = '0;
    Error_current_Section = 1'b0;
    out_ready             = 1'b0;
    model_clear();
    test_reset();
    test_clean_stream();
    test_single_error();
    test_persistent_error();
    test_full_fifo();
    test_back_to_back_full();
    test_reset_during_replay();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
